// File: rtl/jedro_1_mem_arbiter.sv
// Arbitrates one single-port, single-cycle-latency memory between the fetch unit
// and the load/store unit, with window/alignment checks and response routing.
module jedro_1_mem_arbiter #(
  parameter logic [31:0] MEM_BASE       = 32'h8000_0000,
  parameter int          MEM_WORDS      = 4096,
  parameter int          MAX_LSU_STREAK = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ifu_req_i,
  input  logic [31:0]                  ifu_addr_i,
  output logic                         ifu_gnt_o,
  output logic                         ifu_rvalid_o,
  output logic [31:0]                  ifu_rdata_o,
  output logic                         ifu_err_o,
  input  logic                         lsu_req_i,
  input  logic                         lsu_we_i,
  input  logic [3:0]                   lsu_be_i,
  input  logic [31:0]                  lsu_addr_i,
  input  logic [31:0]                  lsu_wdata_i,
  output logic                         lsu_gnt_o,
  output logic                         lsu_rvalid_o,
  output logic [31:0]                  lsu_rdata_o,
  output logic                         lsu_err_o,
  output logic                         ram_en_o,
  output logic [3:0]                   ram_we_o,
  output logic [$clog2(MEM_WORDS)-1:0] ram_addr_o,
  output logic [31:0]                  ram_wdata_o,
  input  logic [31:0]                  ram_rdata_i
);
  localparam int          AW = $clog2(MEM_WORDS);
  localparam int          SW = $clog2(MAX_LSU_STREAK + 1);
  localparam logic [32:0] LO = {1'b0, MEM_BASE};
  localparam logic [32:0] HI = LO + 33'(MEM_WORDS) * 33'd4;
  localparam logic [SW-1:0] SMAX = SW'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_LSU} owner_e;

  owner_e        owner_q, owner_d;
  logic          err_q, err_d;
  logic          store_q, store_d;
  logic [SW-1:0] streak_q, streak_d;

  logic        lsu_win, gnt_ifu, gnt_lsu, any_gnt, legal;
  logic [31:0] acc_addr, off;
  logic [31:0] rsp_data;

  always_comb begin
    // LSU wins contention unless the fetch side has waited out the streak limit
    lsu_win  = lsu_req_i && !(ifu_req_i && (streak_q == SMAX));
    gnt_lsu  = !rst_i && lsu_win;
    gnt_ifu  = !rst_i && ifu_req_i && !lsu_win;
    any_gnt  = gnt_lsu || gnt_ifu;
    acc_addr = lsu_win ? lsu_addr_i : ifu_addr_i;
    // 33-bit compare keeps the top-of-window bound from wrapping
    legal    = ({1'b0, acc_addr} >= LO) && ({1'b0, acc_addr} < HI) && (acc_addr[1:0] == 2'b00);
    off      = acc_addr - MEM_BASE;

    ifu_gnt_o   = gnt_ifu;
    lsu_gnt_o   = gnt_lsu;
    ram_en_o    = any_gnt && legal;
    ram_addr_o  = ram_en_o ? off[AW+1:2] : '0;
    ram_wdata_o = ram_en_o ? lsu_wdata_i : 32'h0;
    ram_we_o    = (ram_en_o && gnt_lsu && lsu_we_i) ? lsu_be_i : 4'b0000;

    streak_d = streak_q;
    if (!ifu_req_i || gnt_ifu) streak_d = '0;
    else if (gnt_lsu && (streak_q != SMAX)) streak_d = streak_q + 1'b1;

    owner_d = gnt_lsu ? OWN_LSU : (gnt_ifu ? OWN_IFU : OWN_NONE);
    err_d   = any_gnt && !legal;
    store_d = gnt_lsu && lsu_we_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      store_q  <= 1'b0;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_d;
      err_q    <= err_d;
      store_q  <= store_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    rsp_data     = (err_q || store_q) ? 32'h0 : ram_rdata_i;
    ifu_rvalid_o = (owner_q == OWN_IFU);
    ifu_rdata_o  = ifu_rvalid_o ? rsp_data : 32'h0;
    ifu_err_o    = ifu_rvalid_o && err_q;
    lsu_rvalid_o = (owner_q == OWN_LSU);
    lsu_rdata_o  = lsu_rvalid_o ? rsp_data : 32'h0;
    lsu_err_o    = lsu_rvalid_o && err_q;
  end
endmodule
